// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the data RAM controller.
package data_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Deepest supported read latency (core register plus one output stage).
  localparam int unsigned LAT_MAX = 2;

  // Number of byte lanes in a data word.
  function automatic int unsigned be_width(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/data_ram_core.sv
// Storage array: byte-enabled synchronous write, one-cycle registered read.
module data_ram_core
  import data_ram_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DWIDTH-1:0]             wdata,
  input  logic [be_width(DWIDTH)-1:0]   be,
  output logic [DWIDTH-1:0]             rdata
);

  localparam int unsigned BW    = be_width(DWIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Byte-lane write; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only updates on a read so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_ctrl.sv
// Data RAM controller: clear engine, request handshake and read latency pipeline.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned DWIDTH         = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DWIDTH-1:0]             req_wdata,
  input  logic [be_width(DWIDTH)-1:0]   req_be,
  output logic                          rsp_valid,
  output logic [DWIDTH-1:0]             rsp_rdata,
  output logic                          init_done
);

  localparam int unsigned BW    = be_width(DWIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam state_t        RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  // Parameter legality checks at elaboration.
  if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
    $error("data_ram_ctrl: DWIDTH must be a multiple of 8");
  end
  if ((RD_LATENCY < 1) || (RD_LATENCY > LAT_MAX)) begin : g_bad_latency
    $error("data_ram_ctrl: RD_LATENCY must be 1 or 2");
  end

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic              clearing;
  logic              accept;
  logic              rd_accept;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [BW-1:0]     mem_be;
  logic [DWIDTH-1:0] core_rdata;
  logic              rd_v1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave CLEAR after writing the last address.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (cnt == CNT_LAST) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RST_STATE;
    endcase
  end

  // Clear address counter, restarted by every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Sticky init flag, set on entry to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done <= 1'b0;
    end else if (state_next == RUN) begin
      init_done <= 1'b1;
    end
  end

  assign clearing  = (state == CLEAR);
  assign req_ready = (state == RUN);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;

  // Array port mux: the clear engine owns the port while clearing.
  always_comb begin
    mem_we    = accept & req_we;
    mem_re    = rd_accept;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_be    = req_be;
    if (clearing) begin
      mem_we    = 1'b1;
      mem_re    = 1'b0;
      mem_addr  = cnt[ADDR_WIDTH-1:0];
      mem_wdata = '0;
      mem_be    = '1;
    end
  end

  data_ram_core #(
    .DWIDTH     (DWIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .rdata (core_rdata)
  );

  // Valid bit tracking the core read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_accept;
    end
  end

  if (RD_LATENCY >= 2) begin : g_lat2
    logic              rd_v2;
    logic [DWIDTH-1:0] rdata2;

    // Extra output stage; data only moves when a response is in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_v2  <= 1'b0;
        rdata2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          rdata2 <= core_rdata;
        end
      end
    end

    assign rsp_valid = rd_v2;
    assign rsp_rdata = rdata2;
  end else begin : g_lat1
    assign rsp_valid = rd_v1;
    assign rsp_rdata = core_rdata;
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench: latency-1 and latency-2 clearing instances plus a no-clear instance.
module tb_data_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        rv, rwe;
  logic [7:0]  raddr;
  logic [15:0] rwd;
  logic [1:0]  rbe;
  logic        rv2, rwe2;
  logic [7:0]  raddr2;
  logic [15:0] rwd2;
  logic [1:0]  rbe2;

  logic        ready0, valid0, done0;
  logic [15:0] rdata0;
  logic        ready1, valid1, done1;
  logic [15:0] rdata1;
  logic        ready2, valid2, done2;
  logic [15:0] rdata2;

  int checks = 0;
  int failures = 0;

  data_ram_ctrl #(.DWIDTH(16), .ADDR_WIDTH(8), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(ready0), .req_we(rwe),
    .req_addr(raddr), .req_wdata(rwd), .req_be(rbe),
    .rsp_valid(valid0), .rsp_rdata(rdata0), .init_done(done0));

  data_ram_ctrl #(.DWIDTH(16), .ADDR_WIDTH(8), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(ready1), .req_we(rwe),
    .req_addr(raddr), .req_wdata(rwd), .req_be(rbe),
    .rsp_valid(valid1), .rsp_rdata(rdata1), .init_done(done1));

  data_ram_ctrl #(.DWIDTH(16), .ADDR_WIDTH(8), .RD_LATENCY(1), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(ready2), .req_we(rwe2),
    .req_addr(raddr2), .req_wdata(rwd2), .req_be(rbe2),
    .rsp_valid(valid2), .rsp_rdata(rdata2), .init_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One single-cycle request on the shared port, with response timing checks.
  task automatic run_vec(input vec_t v);
    rv = 1'b1; rwe = v.we; raddr = v.addr; rwd = v.wdata; rbe = v.be;
    tick();
    rv = 1'b0;
    if (!v.we) begin
      check("lat1_valid", 32'(valid0), 32'd1);
      check("lat1_data", 32'(rdata0), 32'(v.exp));
      check("lat2_not_early", 32'(valid1), 32'd0);
      tick();
      check("lat1_pulse_width", 32'(valid0), 32'd0);
      check("lat1_data_hold", 32'(rdata0), 32'(v.exp));
      check("lat2_valid", 32'(valid1), 32'd1);
      check("lat2_data", 32'(rdata1), 32'(v.exp));
      tick();
      check("lat2_pulse_width", 32'(valid1), 32'd0);
    end else begin
      check("write_no_rsp_a", 32'({valid0, valid1}), 32'd0);
      tick();
      check("write_no_rsp_b", 32'({valid0, valid1}), 32'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 8'h10, 16'hABCD, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000};
    vecs[2]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hAB34};
    vecs[3]  = '{1'b1, 8'h20, 16'h5A5A, 2'b11, 16'h0000};
    vecs[4]  = '{1'b0, 8'h20, 16'h0000, 2'b00, 16'h5A5A};
    vecs[5]  = '{1'b1, 8'h30, 16'hFFFF, 2'b10, 16'h0000};
    vecs[6]  = '{1'b0, 8'h30, 16'h0000, 2'b00, 16'hFF00};
    vecs[7]  = '{1'b1, 8'h30, 16'h1111, 2'b00, 16'h0000};
    vecs[8]  = '{1'b0, 8'h30, 16'h0000, 2'b00, 16'hFF00};
    vecs[9]  = '{1'b0, 8'h99, 16'h0000, 2'b00, 16'h0000};
    vecs[10] = '{1'b1, 8'hFF, 16'hC3C3, 2'b11, 16'h0000};
    vecs[11] = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'hC3C3};
    vecs[12] = '{1'b1, 8'h00, 16'h7E7E, 2'b11, 16'h0000};
    vecs[13] = '{1'b0, 8'h00, 16'h0000, 2'b00, 16'h7E7E};

    rst = 1'b1; rv = 1'b0; rwe = 1'b0; raddr = '0; rwd = '0; rbe = '0;
    rv2 = 1'b0; rwe2 = 1'b0; raddr2 = '0; rwd2 = '0; rbe2 = '0;
    tick();
    tick();

    // Reset state
    check("rst_ready0", 32'(ready0), 32'd0);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);

    // Clear with a read of 0x10 held pending throughout
    rst = 1'b0; rv = 1'b1; rwe = 1'b0; raddr = 8'h10;
    n = 0;
    while (!ready0 && n < 400) begin
      tick();
      n++;
      if (n == 255) check("init_low_before_run", 32'(done0), 32'd0);
    end
    check("clear_cycles", 32'(n), 32'd256);
    check("init_done0", 32'(done0), 32'd1);
    check("init_done1", 32'(done1), 32'd1);
    check("ready1_after_clear", 32'(ready1), 32'd1);
    tick();
    rv = 1'b0;
    check("pending_rd_valid0", 32'(valid0), 32'd1);
    check("pending_rd_data0", 32'(rdata0), 32'd0);
    tick();
    check("pending_rd_valid1", 32'(valid1), 32'd1);
    check("pending_rd_data1", 32'(rdata1), 32'd0);
    tick();

    // Table-driven vectors
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Streaming writes then back-to-back reads
    for (int i = 0; i < 8; i++) begin
      rv = 1'b1; rwe = 1'b1; raddr = 8'(i); rwd = 16'(i * 3); rbe = 2'b11;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      rwe = 1'b0; raddr = 8'(i);
      tick();
      check("stream_valid0", 32'(valid0), 32'd1);
      check("stream_data0", 32'(rdata0), 32'(i * 3));
      if (i > 0) begin
        check("stream_valid1", 32'(valid1), 32'd1);
        check("stream_data1", 32'(rdata1), 32'((i - 1) * 3));
      end
    end
    rv = 1'b0;
    tick();
    check("stream_end_valid0", 32'(valid0), 32'd0);
    check("stream_last_valid1", 32'(valid1), 32'd1);
    check("stream_last_data1", 32'(rdata1), 32'd21);
    tick();
    check("stream_end_valid1", 32'(valid1), 32'd0);

    // Read-after-write on consecutive cycles
    rv = 1'b1; rwe = 1'b1; raddr = 8'h44; rwd = 16'hBEEF; rbe = 2'b11;
    tick();
    rwe = 1'b0;
    tick();
    rv = 1'b0;
    check("raw_valid0", 32'(valid0), 32'd1);
    check("raw_data0", 32'(rdata0), 32'hBEEF);
    tick();
    check("raw_data1", 32'(rdata1), 32'hBEEF);
    tick();

    // Reset the cycle after a read accept
    rv = 1'b1; rwe = 1'b0; raddr = 8'h10;
    tick();
    rv = 1'b0; rst = 1'b1;
    tick();
    check("midrd_valid0", 32'(valid0), 32'd0);
    check("midrd_valid1", 32'(valid1), 32'd0);
    check("midrd_rdata0", 32'(rdata0), 32'd0);
    check("midrd_done0", 32'(done0), 32'd0);
    check("midrd_ready0", 32'(ready0), 32'd0);

    // Reset at clear count 100, with a write held pending
    rst = 1'b0;
    repeat (100) tick();
    check("midclr_still_clearing", 32'(ready0), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; rv = 1'b1; rwe = 1'b1; raddr = 8'h50; rwd = 16'h1357; rbe = 2'b11;
    n = 0;
    while (!ready0 && n < 400) begin
      tick();
      n++;
    end
    check("reclear_cycles", 32'(n), 32'd256);
    check("reclear_done0", 32'(done0), 32'd1);
    tick();
    rv = 1'b0;
    run_vec('{1'b0, 8'h50, 16'h0000, 2'b00, 16'h1357});
    run_vec('{1'b0, 8'h44, 16'h0000, 2'b00, 16'h0000});
    run_vec('{1'b0, 8'hFF, 16'h0000, 2'b00, 16'h0000});

    // No-clear instance keeps contents across reset
    rv2 = 1'b1; rwe2 = 1'b1; raddr2 = 8'h05; rwd2 = 16'hA5A5; rbe2 = 2'b11;
    tick();
    rv2 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("noclr_done_in_rst", 32'(done2), 32'd0);
    check("noclr_ready", 32'(ready2), 32'd1);
    tick();
    check("noclr_done", 32'(done2), 32'd1);
    rv2 = 1'b1; rwe2 = 1'b0; raddr2 = 8'h05;
    tick();
    rv2 = 1'b0;
    check("noclr_valid", 32'(valid2), 32'd1);
    check("noclr_data", 32'(rdata2), 32'hA5A5);
    tick();
    check("noclr_pulse", 32'(valid2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
